// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, imem req/ready handshake, decode field taps
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   imem_req, imem_addr   fetch request and address (address is always pc)
//   imem_ready, imem_rdata memory response; rdata is captured only while requesting
//   stall                 downstream hold; only meaningful while instr_valid=1
//   PCSrc, pc_target      next-PC select and target, sampled on the advance edge
//   instr, instr_valid    registered current instruction and its valid flag
//   op, funct3, funct7_5  decode fields taken straight from instr
//   pc, pc_plus4          address of instr and its sequential successor
//   instret               instructions consumed downstream (wraps at 2^32)
//   misalign_err          sticky misaligned-target flag (FETCH_MISALIGN_TRAP_EN only)
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap on a taken target whose low two
// bits are non-zero (sets misalign_err and parks in HALT until reset). Without it the
// low two target bits are dropped.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instret
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_err
`endif
);

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            capture;
    logic            advance;
    logic            trap_hit;
    logic [XLEN-1:0] next_pc;

    // Masking keeps the whole target bus in use; the low bits only matter to the trap check.
    assign next_pc = PCSrc ? (pc_target & ~XLEN'(3)) : (pc + XLEN'(4));

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap_hit = PCSrc && (pc_target[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                // stall is deliberately ignored here: a ready response is always taken.
                imem_req = 1'b1;
                if (imem_ready) begin
                    capture    = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    advance    = 1'b1;
                    state_next = trap_hit ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            instr   <= NOP_INSTR;
            instret <= '0;
        end else begin
            if (capture) begin
                instr <= imem_rdata;
            end
            if (advance) begin
                // The trapping instruction still retires; only the redirect is suppressed.
                instret <= instret + 32'd1;
                if (!trap_hit) begin
                    pc <= next_pc;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (advance && trap_hit) begin
            misalign_err <= 1'b1;
        end
    end
`endif

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
    assign op        = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_5  = instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        PCSrc;
    logic [31:0] pc_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .PCSrc      (PCSrc),
        .pc_target  (pc_target),
        .instr      (instr),
        .instr_valid(instr_valid),
        .op         (op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instret    (instret)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        stall      = 1'b0;
        PCSrc      = 1'b0;
        pc_target  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0; PCSrc = 1'b0; pc_target = '0;
        #3;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h expected 0", instret); end
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
`endif
        @(posedge clk); #1; rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imem_req); end
        step;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        do_reset; step;
        imem_ready = 1'b1; stall = 1'b0; PCSrc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'(i) * 32'd4;
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %b expected 1", i, imem_req); end
            checks++; if (imem_addr !== a) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, a); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_novalid[%0d]: got %b expected 0", i, instr_valid); end
            imem_rdata = mem_word(a);
            step;
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, instr_valid); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_req_low[%0d]: got %b expected 0", i, imem_req); end
            checks++; if (instr !== mem_word(a)) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, instr, mem_word(a)); end
            checks++; if (pc !== a) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, a); end
            step;
        end
        checks++; if (instret !== 32'd4) begin errors++; $display("FAIL seq_instret: got %0d expected 4", instret); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL seq_addr_end: got %h expected 00000010", imem_addr); end
    endtask

    task automatic test_wait_states;
        do_reset; step;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b expected 1", i, imem_req); end
            checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wait_addr[%0d]: got %h expected 0", i, imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b expected 0", i, instr_valid); end
            checks++; if (instr !== 32'h13) begin errors++; $display("FAIL wait_instr[%0d]: got %h expected 00000013", i, instr); end
            imem_rdata = $urandom;
            step;
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req4: got %b expected 1", imem_req); end
        imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
        step;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wait_cap_valid: got %b expected 1", instr_valid); end
        checks++; if (instr !== mem_word(32'h0)) begin errors++; $display("FAIL wait_cap_instr: got %h expected %h", instr, mem_word(32'h0)); end
    endtask

    task automatic test_fields_stall;
        do_reset; step;
        imem_ready = 1'b1; imem_rdata = 32'h4000_8033;
        step;
        checks++; if (op !== 7'h33) begin errors++; $display("FAIL fld_op: got %h expected 33", op); end
        checks++; if (funct3 !== 3'd0) begin errors++; $display("FAIL fld_funct3: got %h expected 0", funct3); end
        checks++; if (funct7_5 !== 1'b1) begin errors++; $display("FAIL fld_funct7_5: got %b expected 1", funct7_5); end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            PCSrc = 1'($urandom); pc_target = $urandom; imem_rdata = $urandom;
            step;
            checks++; if (instr !== 32'h4000_8033) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected 40008033", i, instr); end
            checks++; if (pc !== 32'h0) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 0", i, pc); end
            checks++; if (instret !== 32'h0) begin errors++; $display("FAIL stall_instret[%0d]: got %0d expected 0", i, instret); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
        end
        stall = 1'b0; PCSrc = 1'b0;
        step;
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL unstall_addr: got %h expected 4", imem_addr); end
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL unstall_instret: got %0d expected 1", instret); end
    endtask

    task automatic test_branch;
        do_reset; step;
        imem_ready = 1'b1; stall = 1'b0; PCSrc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = mem_word(32'(i) * 32'd4);
            step; step;
        end
        imem_rdata = mem_word(32'h10);
        step;
        checks++; if (pc !== 32'h10 || instr_valid !== 1'b1) begin errors++; $display("FAIL br_setup: got pc %h valid %b expected 00000010 1", pc, instr_valid); end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PCSrc = 1'(i); pc_target = $urandom;
            step;
            checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_stall_pc[%0d]: got %h expected 00000010", i, pc); end
        end
        stall = 1'b0; PCSrc = 1'b1; pc_target = 32'h0000_0100;
        step;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr: got req %b addr %h expected 1 00000100", imem_req, imem_addr); end
        PCSrc = 1'b0; imem_rdata = mem_word(32'h100);
        step;
        checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL br_pc_plus4: got %h expected 00000104", pc_plus4); end
        checks++; if (instr !== mem_word(32'h100)) begin errors++; $display("FAIL br_instr: got %h expected %h", instr, mem_word(32'h100)); end
    endtask

    task automatic test_reset_mid_req;
        do_reset; step;
        imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
        step; step;
        imem_ready = 1'b0; imem_rdata = $urandom;
        step;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL mid_setup: got req %b addr %h expected 1 00000004", imem_req, imem_addr); end
        #2; rst = 1'b1; imem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b expected 0", imem_req); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mid_pc: got %h expected 0", pc); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL mid_instr: got %h expected 00000013", instr); end
        @(posedge clk); #1; rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b expected 0", imem_req); end
        step;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_refetch: got req %b addr %h expected 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_misalign;
        do_reset; step;
        imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
        step;
        stall = 1'b0; PCSrc = 1'b1; pc_target = 32'h0000_0102;
        step;
        PCSrc = 1'b0;
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL mis_instret: got %0d expected 1", instret); end
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mis_pc: got %h expected 0", pc); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mis_halt[%0d]: got req %b valid %b expected 0 0", i, imem_req, instr_valid); end
            step;
        end
        do_reset;
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign_err); end
`else
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL mis_noop: got req %b addr %h expected 1 00000100", imem_req, imem_addr); end
`endif
    endtask

    // Reference: a fetch is outstanding until a ready cycle; a held instruction retires on
    // the first non-stalled cycle and redirects to the aligned target or the next word.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] exp_ret;
        logic [31:0] w;
        logic [31:0] tgt;
        logic        exp_req;
        logic        exp_valid;
        logic        rdy;
        logic        stl;
        logic        ps;
        do_reset; step;
        exp_pc = 32'h0; exp_ret = 32'h0; exp_req = 1'b1; exp_valid = 1'b0;
        for (int n = 0; n < 600; n++) begin
            w = mem_word(exp_pc);
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req@%0d: got %b expected %b", n, imem_req, exp_req); end
            checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, instr_valid, exp_valid); end
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h expected %h", n, pc, exp_pc); end
            checks++; if (pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_pc_plus4@%0d: got %h expected %h", n, pc_plus4, exp_pc + 32'd4); end
            checks++; if (instret !== exp_ret) begin errors++; $display("FAIL rnd_instret@%0d: got %0d expected %0d", n, instret, exp_ret); end
            if (exp_valid) begin
                checks++; if (instr !== w) begin errors++; $display("FAIL rnd_instr@%0d: got %h expected %h", n, instr, w); end
                checks++; if (op !== w[6:0] || funct3 !== w[14:12] || funct7_5 !== w[30]) begin errors++; $display("FAIL rnd_fields@%0d: got %h %h %b expected %h %h %b", n, op, funct3, funct7_5, w[6:0], w[14:12], w[30]); end
            end
            rdy = ($urandom_range(0, 2) != 0);
            stl = ($urandom_range(0, 2) == 0);
            ps  = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFFC;
                default: tgt = $urandom;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
            imem_ready = rdy;
            imem_rdata = (exp_req && rdy) ? w : $urandom;
            stall      = stl;
            PCSrc      = ps;
            pc_target  = tgt;
            if (exp_req && rdy) begin
                exp_req = 1'b0; exp_valid = 1'b1;
            end else if (exp_valid && !stl) begin
                exp_valid = 1'b0; exp_req = 1'b1;
                exp_ret   = exp_ret + 32'd1;
                exp_pc    = ps ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
            end
            step;
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_wait_states;
        test_fields_stall;
        test_branch;
        test_reset_mid_req;
        test_misalign;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and fetches from instruction memory over a req/ready handshake.
- Presents the current instruction, plus its op/funct3/funct7_5 fields, to decode.
- Consumes the PCSrc and pc_target that decode/execute compute for the current instruction, and uses them to choose the next PC.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  XLEN  fetch address; equals pc.
- imem_ready  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  XLEN  instruction word from memory.
- stall  input  1  downstream not ready; hold the current instruction.
- PCSrc  input  1  1 = next PC is pc_target; 0 = pc+4.
- pc_target  input  XLEN  branch/jump target for the current instruction.
- instr  output  XLEN  registered current instruction.
- instr_valid  output  1  instr, pc and the field outputs are valid.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7_5  output  1  instr[30].
- pc  output  XLEN  address of instr.
- pc_plus4  output  XLEN  pc+4, for JAL link writeback.
- instret  output  32  count of instructions consumed downstream.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - instr_valid=0, imem_req=0, instret=0, state=IDLE.
  - Asserting rst mid-handshake aborts the fetch immediately; no partial capture.
- States:
  - IDLE: 1 cycle after reset release, imem_req=0, then -> REQ.
  - REQ: imem_req=1, imem_addr=pc held stable.
    - If imem_ready=1 at the clock edge: instr<=imem_rdata, -> VALID.
    - Otherwise stay in REQ. Waits are unbounded; there is no timeout.
  - VALID: instr_valid=1, imem_req=0.
    - Advance when stall=0: pc<=next_pc, instret<=instret+1, -> REQ.
    - stall=1: hold all outputs unchanged.
- next_pc = PCSrc ? {pc_target[XLEN-1:2],2'b00} : pc+4.
  - Arithmetic is modulo 2^XLEN: pc=32'hFFFF_FFFC with PCSrc=0 advances to 0.
- PCSrc and pc_target are sampled only on an advance edge; ignored in IDLE/REQ and while stall=1.
- Latency: from an advance edge to the next instr_valid is at least 2 cycles (REQ with ready=1, then VALID).
- Throughput: one instruction per 2 cycles best case.
- instret wraps 32'hFFFF_FFFF -> 0.
- pc_plus4, op, funct3 and funct7_5 are combinational from the pc/instr registers.
- imem_rdata is ignored whenever the block is not in REQ.
- When imem_ready=1 and stall=1 in the same cycle while in REQ, the capture still happens; stall only acts in VALID.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Extra output misalign_err (1 bit, reset 0).
  - On an advance with PCSrc=1 and pc_target[1:0]!=0: set misalign_err (sticky) and enter HALT instead of REQ; pc is not updated and instret still increments.
  - HALT: imem_req=0, instr_valid=0, exits only on rst.
- Undefined: there is no port; target bits [1:0] are silently cleared as described above.

Test Plan:
- Reset release, imem_ready tied 1, stall=0, PCSrc=0 -> imem_addr sequence 0,4,8,C; instr_valid high every 2nd cycle; instret=4 after 4 advances.
- imem_ready low for 3 cycles in REQ -> imem_req and imem_addr stay stable for 3 cycles; capture on the 4th cycle; instr_valid the following cycle.
- Deliver imem_rdata=32'h4000_8033 -> op=7'h33, funct3=0, funct7_5=1; assert stall=1 for 5 cycles -> instr, pc and instret unchanged throughout.
- With pc=32'h10 and instr_valid=1, drive PCSrc=1, pc_target=32'h0000_0100 -> next imem_addr=32'h100 and pc_plus4=32'h104 once valid; PCSrc toggling during stall has no effect.
- Assert rst while in REQ with imem_ready=0 -> imem_req=0 immediately; after release pc=RESET_PC and the first fetch is from RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, pc_target=32'h102, PCSrc=1, advance -> misalign_err=1, imem_req stays 0 until rst. Without the macro, the same stimulus fetches from 32'h100.
